// File: rtl/rr_grant_indexer.sv
// rr_grant_indexer
//   Round-robin arbiter over 2**N requesters. It produces a registered binary
//   grant index that drives an N:2**N one-hot decoder, and a valid flag that
//   gates the decoder output at the consumer. A grant is held until the owner
//   pulses done or drops its request. After every release there is at least
//   one idle cycle before the next grant.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   req        request vector, bit i = requester i
//   done       single-cycle pulse from the current owner ending its grant
//   gnt_idx    binary index of the current owner (decoder select)
//   gnt_valid  high while gnt_idx names a live grant
//   ptr        current priority pointer (visibility)
module rr_grant_indexer #(
    parameter int N = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2**N-1:0] req,
    input  logic            done,
    output logic [N-1:0]    gnt_idx,
    output logic            gnt_valid,
    output logic [N-1:0]    ptr
);
    localparam int M = 2**N;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t       r_state;
    logic [N-1:0] r_gnt_idx;
    logic [N-1:0] r_ptr;
    logic         r_gnt_valid;

    logic [M-1:0] w_rot;
    logic [N-1:0] w_off;
    logic [N-1:0] w_winner;
    logic         w_any;
    logic         w_release;

    // Rotate req so that bit 0 of w_rot is the requester named by ptr.
    // The N-bit index sum wraps naturally modulo 2**N.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < M; i++) begin
            w_rot[i] = req[r_ptr + N'(i)];
        end
    end

    // Lowest set bit of the rotated vector is the nearest requester at or
    // after ptr. Scanning from the top lets the lowest hit win.
    always_comb begin
        w_off = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = N'(i);
        end
    end

    assign w_winner  = r_ptr + w_off;
    assign w_any     = |req;
    // done and the owner's request dropping together is one release.
    assign w_release = done || !req[r_gnt_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Always entered for at least one cycle after a release,
                    // which gives the consumer its gap between grants.
                    if (w_any) begin
                        r_state     <= S_GRANT;
                        r_gnt_idx   <= w_winner;
                        r_gnt_valid <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state     <= S_IDLE;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_idx + N'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign ptr       = r_ptr;

endmodule

// File: tb/tb_rr_grant_indexer.sv
module tb_rr_grant_indexer;
    localparam int N = 3;
    localparam int M = 2**N;

    logic         clk = 1'b0;
    logic         rst;
    logic [M-1:0] req;
    logic         done;
    logic [N-1:0] gnt_idx;
    logic         gnt_valid;
    logic [N-1:0] ptr;

    int n_tot  = 0;
    int n_pass = 0;

    // Behavioural model state
    int m_busy = 0;
    int m_idx  = 0;
    int m_ptr  = 0;

    rr_grant_indexer #(.N(N)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .ptr(ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: one owner at a time, winner is the first requester found walking
    // upward from the pointer around the ring.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_idx = 0; m_ptr = 0;
        end else if (m_busy != 0) begin
            if (done || !req[m_idx]) begin
                m_busy = 0;
                m_ptr  = (m_idx + 1) % M;
            end
        end else if (req != 0) begin
            for (int k = M - 1; k >= 0; k--) begin
                if (req[(m_ptr + k) % M]) m_idx = (m_ptr + k) % M;
            end
            m_busy = 1;
        end
    end

    // Compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_valid", 32'(gnt_valid), 32'(m_busy));
            chk("model_idx",   32'(gnt_idx),   32'(m_idx));
            chk("model_ptr",   32'(ptr),       32'(m_ptr));
        end
    end

    initial begin
        rst = 1'b0; req = '0; done = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(gnt_valid), 0);
        chk("rst_idx",   32'(gnt_idx),   0);
        chk("rst_ptr",   32'(ptr),       0);
        tick();
        rst = 1'b0;

        // Single request
        req = 8'h04;
        tick();
        chk("t1_valid", 32'(gnt_valid), 1);
        chk("t1_idx",   32'(gnt_idx),   2);
        done = 1'b1;
        tick();
        done = 1'b0; req = '0;
        chk("t1_rel_valid", 32'(gnt_valid), 0);
        chk("t1_rel_ptr",   32'(ptr),       3);

        // Rotation fairness from ptr=0
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rot_valid", 32'(gnt_valid), 1);
            chk("rot_idx",   32'(gnt_idx),   32'(i % M));
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("rot_gap", 32'(gnt_valid), 0);
            chk("rot_ptr", 32'(ptr),       32'((i + 1) % M));
        end
        req = '0;
        tick();

        // Pointer skip: ptr=3, req=0000_0011 -> 0 then 1
        req = 8'h04;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("skip_ptr3", 32'(ptr), 3);
        req = 8'h03;
        tick();
        chk("skip_idx0", 32'(gnt_idx), 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("skip_ptr1", 32'(ptr), 1);
        tick();
        chk("skip_idx1",   32'(gnt_idx),   1);
        chk("skip_valid1", 32'(gnt_valid), 1);
        req = '0;
        tick();

        // Owner drop without done, neighbour waits for the gap
        req = 8'h20;
        tick();
        chk("drop_idx5", 32'(gnt_idx), 5);
        req = 8'h40;
        tick();
        chk("drop_valid", 32'(gnt_valid), 0);
        chk("drop_ptr6",  32'(ptr),       6);
        tick();
        chk("drop_idx6",   32'(gnt_idx),   6);
        chk("drop_valid6", 32'(gnt_valid), 1);
        req = '0;
        tick();

        // Async reset mid-grant
        req = 8'h10;
        tick();
        chk("ar_idx4", 32'(gnt_idx), 4);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(gnt_valid), 0);
        chk("ar_idx",   32'(gnt_idx),   0);
        chk("ar_ptr",   32'(ptr),       0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_regrant_valid", 32'(gnt_valid), 1);
        chk("ar_regrant_idx",   32'(gnt_idx),   4);
        req = '0;
        tick();

        // Stability while other bits toggle
        req = 8'h04;
        tick();
        for (int i = 0; i < 6; i++) begin
            req = 8'($urandom) | 8'h04;
            tick();
            chk("stab_idx",   32'(gnt_idx),   2);
            chk("stab_valid", 32'(gnt_valid), 1);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("stab_rel", 32'(gnt_valid), 0);
        req = '0;

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) req = ($urandom_range(0, 2) == 0) ? '0 : 8'($urandom);
            done = ($urandom_range(0, 4) == 0);
            tick();
        end
        req = '0; done = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
